// File: rtl/display_device_if.sv
// Display-side bundle: refresh strobe, edit-path state, time fields and the registered segment/anode drive.
// The master drives the inputs; the display device consumes them as slave and returns o_seg/o_an.
interface display_device_if;
  logic       i_ena;
  logic       i_wr;
  logic [1:0] i_sel;
  logic [7:0] i_secs;
  logic [7:0] i_mins;
  logic [7:0] i_hours;
  logic [7:0] i_val;
  logic [7:0] o_seg;
  logic [2:0] o_an;

  modport master (
    output i_ena, i_wr, i_sel, i_secs, i_mins, i_hours, i_val,
    input  o_seg, o_an
  );

  modport slave (
    input  i_ena, i_wr, i_sel, i_secs, i_mins, i_hours, i_val,
    output o_seg, o_an
  );
endinterface

// File: rtl/display_device.sv
// 3-digit multiplexed 7-segment driver: letter + two BCD digits, blinks in edit mode.
// Outputs update on the i_ena edge; BCD refresh <=10 clocks after frame wrap; no backpressure (i_ena spacing >=12).
module display_device #(
  parameter int BLINK_TICKS = 250
) (
  input  logic             i_clk,
  input  logic             i_reset,
  display_device_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [1:0]       idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;
  logic [0:0]       state_q, state_d;
  logic [7:0]       rem_q, rem_d;
  logic [3:0]       tens_q, tens_d;
  logic             none_q, none_d;
  logic [3:0]       disp_tens_q, disp_tens_d;
  logic [3:0]       disp_ones_q, disp_ones_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             hidden_q, hidden_d;

  logic [1:0] idx_nxt;
  logic       value_hidden;
  logic [7:0] src_val;
  logic       src_none;

  function automatic logic [7:0] seg_of(input logic [3:0] code);
    case (code)
      4'd0:    seg_of = 8'hC0;
      4'd1:    seg_of = 8'hF9;
      4'd2:    seg_of = 8'hA4;
      4'd3:    seg_of = 8'hB0;
      4'd4:    seg_of = 8'h99;
      4'd5:    seg_of = 8'h92;
      4'd6:    seg_of = 8'h82;
      4'd7:    seg_of = 8'hF8;
      4'd8:    seg_of = 8'h80;
      4'd9:    seg_of = 8'h90;
      4'hA:    seg_of = 8'hBF;
      default: seg_of = 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] letter_of(input logic [1:0] sel);
    case (sel)
      2'd0:    letter_of = 8'h92;
      2'd1:    letter_of = 8'hAB;
      2'd2:    letter_of = 8'h8B;
      default: letter_of = 8'hFF;
    endcase
  endfunction

  assign idx_nxt      = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
  assign value_hidden = bus.i_wr && hidden_q;

  always_comb begin
    src_val  = bus.i_val;
    src_none = 1'b0;
    if (!bus.i_wr) begin
      case (bus.i_sel)
        2'd0:    src_val = bus.i_secs;
        2'd1:    src_val = bus.i_mins;
        2'd2:    src_val = bus.i_hours;
        default: begin
          src_val  = 8'd0;
          src_none = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    idx_d       = idx_q;
    seg_d       = seg_q;
    an_d        = an_q;
    state_d     = state_q;
    rem_d       = rem_q;
    tens_d      = tens_q;
    none_d      = none_q;
    disp_tens_d = disp_tens_q;
    disp_ones_d = disp_ones_q;
    blink_cnt_d = blink_cnt_q;
    hidden_d    = hidden_q;

    // The digit driven on a tick is the one the index is about to point at.
    if (bus.i_ena) begin
      idx_d = idx_nxt;
      case (idx_nxt)
        2'd0: begin
          an_d  = 3'b110;
          seg_d = value_hidden ? 8'hFF : seg_of(disp_ones_q);
        end
        2'd1: begin
          an_d  = 3'b101;
          seg_d = value_hidden ? 8'hFF : seg_of(disp_tens_q);
        end
        default: begin
          an_d  = 3'b011;
          seg_d = letter_of(bus.i_sel) & {~bus.i_wr, 7'h7F};
        end
      endcase
    end

    if (!bus.i_wr) begin
      blink_cnt_d = '0;
      hidden_d    = 1'b0;
    end else if (bus.i_ena) begin
      if (blink_cnt_q == CNT_W'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        hidden_d    = ~hidden_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end

    // Display registers are written only on completion so a frame never sees partial digits.
    case (state_q)
      ST_IDLE: begin
        if (bus.i_ena && (idx_q == 2'd2)) begin
          state_d = ST_CONV;
          rem_d   = src_val;
          tens_d  = 4'd0;
          none_d  = src_none;
        end
      end
      default: begin
        if (none_q) begin
          disp_tens_d = CODE_BLANK;
          disp_ones_d = CODE_BLANK;
          state_d     = ST_IDLE;
        end else if (rem_q >= 8'd100) begin
          disp_tens_d = CODE_DASH;
          disp_ones_d = CODE_DASH;
          state_d     = ST_IDLE;
        end else if (rem_q >= 8'd10) begin
          rem_d  = rem_q - 8'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          disp_tens_d = tens_q;
          disp_ones_d = rem_q[3:0];
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idx_q       <= 2'd0;
      seg_q       <= 8'hFF;
      an_q        <= 3'b111;
      state_q     <= ST_IDLE;
      rem_q       <= 8'd0;
      tens_q      <= 4'd0;
      none_q      <= 1'b0;
      disp_tens_q <= 4'd0;
      disp_ones_q <= 4'd0;
      blink_cnt_q <= '0;
      hidden_q    <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      state_q     <= state_d;
      rem_q       <= rem_d;
      tens_q      <= tens_d;
      none_q      <= none_d;
      disp_tens_q <= disp_tens_d;
      disp_ones_q <= disp_ones_d;
      blink_cnt_q <= blink_cnt_d;
      hidden_q    <= hidden_d;
    end
  end

  assign bus.o_seg = seg_q;
  assign bus.o_an  = an_q;

endmodule

// File: tb/tb_display_device.sv
// Directed + randomized bench for display_device against a frame-level reference model.
module tb_display_device;
  localparam int BT = 4;

  logic clk = 1'b0;
  logic rst;

  display_device_if io ();

  display_device #(.BLINK_TICKS(BT)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: what each digit shows, plus the value sampled at the last frame start.
  int         m_idx;
  int         m_val;
  int         m_kind;   // 0 = number, 1 = dash, 2 = blank
  bit         m_pend;
  int         p_val;
  int         p_kind;
  int         m_cnt;
  bit         m_hidden;
  logic [7:0] last_seg;
  logic [2:0] last_an;

  function automatic logic [7:0] digit_seg(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      default: return 8'h90;
    endcase
  endfunction

  function automatic logic [7:0] letter_seg(input logic [1:0] s);
    case (s)
      2'd0: return 8'h92;
      2'd1: return 8'hAB;
      2'd2: return 8'h8B;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] value_seg(input int kind, input int d);
    if (kind == 1) return 8'hBF;
    if (kind == 2) return 8'hFF;
    return digit_seg(d);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idx    = 0;
    m_val    = 0;
    m_kind   = 0;
    m_pend   = 0;
    m_cnt    = 0;
    m_hidden = 0;
    last_seg = 8'hFF;
    last_an  = 3'b111;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("reset_seg", io.o_seg, 8'hFF);
    check("reset_an", {5'd0, io.o_an}, 8'h07);
  endtask

  task automatic set_wr(input bit w);
    io.i_wr = w;
    if (!w) begin
      m_cnt    = 0;
      m_hidden = 0;
    end
  endtask

  task automatic tick(input string tag);
    int nidx;
    int v;
    logic [7:0] es;
    logic [2:0] ea;
    if (m_pend) begin
      m_val  = p_val;
      m_kind = p_kind;
      m_pend = 0;
    end
    nidx = (m_idx + 1) % 3;
    if (nidx == 2) begin
      ea = 3'b011;
      es = letter_seg(io.i_sel) & (io.i_wr ? 8'h7F : 8'hFF);
    end else if (nidx == 1) begin
      ea = 3'b101;
      es = (io.i_wr && m_hidden) ? 8'hFF : value_seg(m_kind, m_val / 10);
    end else begin
      ea = 3'b110;
      es = (io.i_wr && m_hidden) ? 8'hFF : value_seg(m_kind, m_val % 10);
    end
    if (nidx == 0) begin
      if (io.i_wr) v = int'(io.i_val);
      else if (io.i_sel == 2'd0) v = int'(io.i_secs);
      else if (io.i_sel == 2'd1) v = int'(io.i_mins);
      else if (io.i_sel == 2'd2) v = int'(io.i_hours);
      else v = -1;
      if (v < 0) begin
        p_val  = 0;
        p_kind = 2;
      end else begin
        p_val  = v;
        p_kind = (v >= 100) ? 1 : 0;
      end
      m_pend = 1;
    end
    if (io.i_wr) begin
      m_cnt++;
      if (m_cnt == BT) begin
        m_cnt    = 0;
        m_hidden = !m_hidden;
      end
    end
    m_idx = nidx;
    io.i_ena = 1'b1;
    @(posedge clk); #1;
    io.i_ena = 1'b0;
    check({tag, "_seg"}, io.o_seg, es);
    check({tag, "_an"}, {5'd0, io.o_an}, {5'd0, ea});
    last_seg = es;
    last_an  = ea;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
    check("hold_seg", io.o_seg, last_seg);
    check("hold_an", {5'd0, io.o_an}, {5'd0, last_an});
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick(tag);
      gap(11);
    end
  endtask

  initial begin
    rst        = 1'b1;
    io.i_ena   = 1'b0;
    io.i_wr    = 1'b0;
    io.i_sel   = 2'd0;
    io.i_secs  = 8'd0;
    io.i_mins  = 8'd0;
    io.i_hours = 8'd0;
    io.i_val   = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    ticks("secs0", 3);

    io.i_sel  = 2'd1;
    io.i_mins = 8'd47;
    ticks("mins47", 6);

    io.i_val = 8'd59;
    set_wr(1'b1);
    ticks("blink59", 18);

    set_wr(1'b0);
    io.i_sel   = 2'd2;
    io.i_hours = 8'd150;
    ticks("hours150", 6);

    io.i_hours = 8'd99;
    ticks("hours99", 6);

    io.i_sel = 2'd3;
    ticks("none", 6);

    io.i_sel  = 2'd0;
    io.i_secs = 8'd12;
    while (m_idx != 2) ticks("align", 1);
    ticks("secs12", 3);
    tick("wrap12");
    @(posedge clk); #1;
    io.i_secs = 8'd34;
    gap(10);
    ticks("secs12to34", 8);

    io.i_sel  = 2'd1;
    io.i_mins = 8'd59;
    while (m_idx != 2) ticks("align", 1);
    tick("wrap59");
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    io.i_mins = 8'd0;
    gap(11);
    ticks("after_rst", 3);
    io.i_mins = 8'd59;
    ticks("after_rst59", 6);

    for (int i = 0; i < 90; i++) begin
      if ($urandom_range(0, 3) == 0) set_wr(1'($urandom_range(0, 1)));
      io.i_sel   = 2'($urandom_range(0, 3));
      io.i_secs  = 8'($urandom_range(0, 120));
      io.i_mins  = 8'($urandom_range(0, 120));
      io.i_hours = 8'($urandom_range(0, 255));
      io.i_val   = 8'($urandom_range(0, 110));
      tick("rand");
      gap($urandom_range(11, 18));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
